fifo_pkt_writer: RTL and testbench

Write-side packet framer that feeds the write port of the team's asynchronous FIFO in the `wr_clk` domain. It accepts a packet command (a payload length) and a payload word stream. It writes a length header word, then the payload words, and optionally a checksum trailer into the FIFO. It honours the FIFO `full` flag so that no word is ever dropped. The read-side deframer in the `rd_clk` domain consumes the same framing.

---
 rtl/fifo_pkt_writer.sv | 129 ++++++++++++
 tb/tb_fifo_pkt_writer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pkt_writer.sv
// Write-side packet framer for the async FIFO: emits a length header, then the payload words.
// Define PKT_CSUM_EN to append a modulo-2^DATA_WIDTH checksum trailer to every packet.
module fifo_pkt_writer #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  wr_clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  fifo_full,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_wr_data,
    output logic                  busy,
    output logic                  pkt_done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR  = 2'd1;
    localparam logic [1:0] ST_PAY  = 2'd2;
`ifdef PKT_CSUM_EN
    localparam logic [1:0] ST_CSUM = 2'd3;
    localparam logic [1:0] ST_TAIL = ST_CSUM;
`else
    localparam logic [1:0] ST_TAIL = ST_IDLE;
`endif

    generate
        if (LEN_WIDTH > DATA_WIDTH) begin : g_len_width_check
            $error("fifo_pkt_writer: LEN_WIDTH must not exceed DATA_WIDTH");
        end
    endgenerate

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [LEN_WIDTH-1:0]  rem;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [DATA_WIDTH-1:0] hdr_word;
    logic                  cmd_take;

    // The header comes from a latched copy so cmd_len may change once the command is taken.
    assign hdr_word  = DATA_WIDTH'(len_q);
    assign cmd_take  = (state == ST_IDLE) && cmd_valid;
    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

`ifdef PKT_CSUM_EN
    logic [DATA_WIDTH-1:0] acc;

    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (cmd_take) begin
            acc <= '0;
        end else if ((state == ST_PAY) && fifo_wr_en) begin
            acc <= acc + s_data;
        end
    end
`endif

    always_comb begin
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        s_ready      = 1'b0;
        case (state)
            ST_HDR: begin
                fifo_wr_en   = !fifo_full;
                fifo_wr_data = hdr_word;
            end
            ST_PAY: begin
                s_ready      = !fifo_full;
                fifo_wr_en   = s_valid && !fifo_full;
                fifo_wr_data = s_data;
            end
`ifdef PKT_CSUM_EN
            ST_CSUM: begin
                fifo_wr_en   = !fifo_full;
                fifo_wr_data = acc;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) state_nxt = ST_HDR;
            end
            ST_HDR: begin
                if (fifo_wr_en) state_nxt = (rem != '0) ? ST_PAY : ST_TAIL;
            end
            ST_PAY: begin
                if (fifo_wr_en && (rem == LEN_WIDTH'(1))) state_nxt = ST_TAIL;
            end
`ifdef PKT_CSUM_EN
            ST_CSUM: begin
                if (fifo_wr_en) state_nxt = ST_IDLE;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Any return to IDLE from a busy state is the edge of a packet's final write.
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            rem      <= '0;
            len_q    <= '0;
            pkt_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            pkt_done <= (state != ST_IDLE) && (state_nxt == ST_IDLE);
            if (cmd_take) begin
                rem   <= cmd_len;
                len_q <= cmd_len;
            end else if ((state == ST_PAY) && fifo_wr_en) begin
                rem <= rem - LEN_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_pkt_writer.sv
// Self-checking bench for fifo_pkt_writer: vector table, hand sequences and randomized packets
// checked against a queue-based framing model.
module tb_fifo_pkt_writer;

`ifdef PKT_CSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic       wr_clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_len;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       fifo_full;
    logic       fifo_wr_en;
    logic [7:0] fifo_wr_data;
    logic       busy;
    logic       pkt_done;

    fifo_pkt_writer #(.DATA_WIDTH(8), .LEN_WIDTH(8)) dut (
        .wr_clk(wr_clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .busy(busy), .pkt_done(pkt_done)
    );

    always #5 wr_clk = ~wr_clk;

    int n_chk  = 0;
    int n_pass = 0;
    int pd_cnt = 0;
    logic [7:0] wq[$];
    logic [7:0] exp_q[$];
    logic [7:0] pay[$];

    typedef struct {
        int         len;
        logic [7:0] d0, d1, d2;
        int         stall_at;
        int         stall_cyc;
        logic [7:0] csum;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Write monitor: a write is wr_en high at the coming edge; inputs only change just after edges.
    always @(negedge wr_clk) begin
        if (!rst) begin
            if (fifo_wr_en) wq.push_back(fifo_wr_data);
            if (pkt_done) pd_cnt++;
            if (fifo_full) chk("stall_wr_en_s_ready", {30'b0, fifo_wr_en, s_ready}, 32'd0);
            if (pkt_done) chk("done_with_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        end
    end

    task automatic model_expect(input int len);
        logic [7:0] sum = 8'h00;
        logic [7:0] l8;
        l8 = len[7:0];
        exp_q.delete();
        exp_q.push_back(l8);
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(pay[i]);
            sum = sum + pay[i];
        end
        if (CS != 0) exp_q.push_back(sum);
    endtask

    task automatic check_stream(input string name);
        int bad = -1;
        chk({name, "_word_count"}, wq.size(), exp_q.size());
        for (int i = 0; i < wq.size() && i < exp_q.size(); i++)
            if (bad < 0 && wq[i] !== exp_q[i]) bad = i;
        if (bad >= 0) chk($sformatf("%s_word%0d", name, bad), {24'b0, wq[bad]}, {24'b0, exp_q[bad]});
        else if (wq.size() > 0) chk({name, "_header"}, {24'b0, wq[0]}, {24'b0, exp_q[0]});
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_cmd_ready"}, {31'b0, cmd_ready}, 32'd1);
        chk({name, "_s_ready"}, {31'b0, s_ready}, 32'd0);
        chk({name, "_wr_en"}, {31'b0, fifo_wr_en}, 32'd0);
        chk({name, "_wr_data"}, {24'b0, fifo_wr_data}, 32'd0);
        chk({name, "_busy"}, {31'b0, busy}, 32'd0);
        chk({name, "_pkt_done"}, {31'b0, pkt_done}, 32'd0);
    endtask

    task automatic run_pkt(input int len, input bit rnd, input int stall_at, input int stall_cyc,
                           input int abort_at);
        int idx = 0, cyc = 0, stall_left = 0, pd0 = pd_cnt;
        int budget = 20 * len + 60;
        bit accepted = 0, done = 0, aborted = 0, timed_out = 0, hs_cmd, hs_dat;
        logic [7:0] l8;
        l8 = len[7:0];
        wq.delete();
        @(posedge wr_clk); #1;
        cmd_valid = 1'b1;
        cmd_len   = l8;
        while (!done) begin
            if (stall_left > 0) begin
                fifo_full = 1'b1;
                stall_left--;
            end else begin
                fifo_full = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
            end
            if (accepted && idx < len) begin
                s_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                s_data  = pay[idx];
            end else begin
                s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                s_data  = 8'($urandom);
            end
            @(negedge wr_clk);
            hs_cmd = cmd_valid && cmd_ready;
            hs_dat = s_valid && s_ready;
            @(posedge wr_clk); #1;
            cyc++;
            if (hs_cmd) begin
                cmd_valid = 1'b0;
                accepted  = 1'b1;
            end
            if (hs_dat) begin
                idx++;
                if (idx == stall_at) stall_left = stall_cyc;
                if (idx == abort_at) begin
                    #2 rst = 1'b1;
                    #1;
                    chk_reset_outputs("abort");
                    aborted = 1'b1;
                    done    = 1'b1;
                end
            end
            if (accepted && !busy) done = 1'b1;
            if (cyc > budget) begin
                timed_out = 1'b1;
                done      = 1'b1;
            end
        end
        cmd_valid = 1'b0;
        s_valid   = 1'b0;
        fifo_full = 1'b0;
        chk("pkt_timeout", {31'b0, timed_out}, 32'd0);
        if (!aborted) begin
            @(negedge wr_clk); #1;
            chk("pkt_done_count", pd_cnt - pd0, 32'd1);
        end
    endtask

    vec_t vecs[6];

    initial begin
        int pd0, idx, accepts, cyc, len;
        bit hs_cmd, hs_dat;

        vecs[0] = '{3, 8'h11, 8'h22, 8'h33, -1, 0, 8'h66};
        vecs[1] = '{3, 8'h11, 8'h22, 8'h33,  2, 4, 8'h66};
        vecs[2] = '{0, 8'h00, 8'h00, 8'h00, -1, 0, 8'h00};
        vecs[3] = '{1, 8'hAB, 8'h00, 8'h00, -1, 0, 8'hAB};
        vecs[4] = '{2, 8'h80, 8'h80, 8'h00, -1, 0, 8'h00};
        vecs[5] = '{3, 8'hFF, 8'h01, 8'h10,  1, 3, 8'h10};

        rst = 1'b1; cmd_valid = 1'b0; cmd_len = 8'h00;
        s_valid = 1'b0; s_data = 8'h00; fifo_full = 1'b0;
        repeat (3) @(negedge wr_clk);
        chk_reset_outputs("reset");
        @(posedge wr_clk); #1 rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            pay.delete();
            pay.push_back(vecs[v].d0); pay.push_back(vecs[v].d1); pay.push_back(vecs[v].d2);
            exp_q.delete();
            exp_q.push_back(vecs[v].len[7:0]);
            for (int i = 0; i < vecs[v].len; i++) exp_q.push_back(pay[i]);
            if (CS != 0) exp_q.push_back(vecs[v].csum);
            run_pkt(vecs[v].len, 1'b0, vecs[v].stall_at, vecs[v].stall_cyc, -1);
            check_stream($sformatf("vec%0d", v));
        end

        // Back-to-back: cmd_valid held, second command taken in the pkt_done cycle.
        pay = '{8'h3C, 8'h81, 8'h47};
        exp_q = '{8'h02, 8'h3C, 8'h81};
        if (CS != 0) exp_q.push_back(8'hBD);
        exp_q.push_back(8'h01); exp_q.push_back(8'h47);
        if (CS != 0) exp_q.push_back(8'h47);
        wq.delete();
        pd0 = pd_cnt; idx = 0; accepts = 0; cyc = 0;
        @(posedge wr_clk); #1;
        cmd_valid = 1'b1; cmd_len = 8'd2; fifo_full = 1'b0;
        while ((accepts < 2 || busy) && cyc < 100) begin
            s_valid = (idx < 3);
            s_data  = (idx < 3) ? pay[idx] : 8'h00;
            @(negedge wr_clk);
            hs_cmd = cmd_valid && cmd_ready;
            hs_dat = s_valid && s_ready;
            if (hs_cmd && accepts == 1) chk("b2b_accept_in_done_cycle", {31'b0, pkt_done}, 32'd1);
            @(posedge wr_clk); #1;
            cyc++;
            if (hs_cmd) accepts++;
            if (accepts == 2) cmd_valid = 1'b0;
            if (hs_dat) begin
                idx++;
                if (idx == 1) cmd_len = 8'd1;
            end
        end
        s_valid = 1'b0;
        chk("b2b_timeout", {31'b0, (cyc >= 100)}, 32'd0);
        @(negedge wr_clk); #1;
        chk("b2b_pkt_done_count", pd_cnt - pd0, 32'd2);
        check_stream("b2b");

        pay.delete();
        for (int i = 0; i < 255; i++) pay.push_back(8'hFF);
        model_expect(255);
        run_pkt(255, 1'b0, -1, 0, -1);
        check_stream("len255");
        chk("len255_idle", {31'b0, busy}, 32'd0);

        for (int p = 0; p < 20; p++) begin
            len = $urandom_range(0, 12);
            pay.delete();
            for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
            model_expect(len);
            run_pkt(len, 1'b1, -1, 0, -1);
            check_stream($sformatf("rand%0d", p));
        end

        pay = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        pd0 = pd_cnt;
        run_pkt(5, 1'b0, -1, 0, 2);
        chk("abort_words_kept", wq.size(), 32'd3);
        repeat (2) @(posedge wr_clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge wr_clk);
        #1;
        chk("abort_no_pkt_done", pd_cnt - pd0, 32'd0);
        pay = '{8'h5A};
        model_expect(1);
        run_pkt(1, 1'b0, -1, 0, -1);
        check_stream("after_reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
